// File: rtl/reaction_timer.sv
// reaction_timer: arm on press, hold off WAIT_MS ticks, light GO, time the next press in BCD ms
module reaction_timer #(
    parameter int TICK_DIV = 50000,
    parameter int WAIT_MS  = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       press_in,
    output logic       go_led,
    output logic       foul,
    output logic       done,
    output logic [3:0] bcd_thou,
    output logic [3:0] bcd_hund,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int WW = $clog2(WAIT_MS + 1);
    typedef enum logic [2:0] {IDLE, ARMED, GO, DONE, FOUL} state_t;
    state_t        state_q;
    logic [PW-1:0] pre_q;
    logic [WW-1:0] wait_q;
    logic [15:0]   bcd_q;
    logic [15:0]   bcd_d;
    logic          ms_tick;
    logic          sat;
    assign ms_tick = pre_q == PW'(TICK_DIV - 1);
    assign sat     = bcd_q == 16'h9999;
    assign {bcd_thou, bcd_hund, bcd_tens, bcd_ones} = bcd_q;
    always_comb begin
        logic c;
        bcd_d = bcd_q;
        c     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                bcd_d[4*i +: 4] = (bcd_q[4*i +: 4] == 4'd9) ? 4'd0 : bcd_q[4*i +: 4] + 4'd1;
                c = bcd_q[4*i +: 4] == 4'd9;
            end
        end
    end
    // Every state change also restarts the prescaler so the first tick lands TICK_DIV cycles later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pre_q   <= '0;
            wait_q  <= '0;
            bcd_q   <= '0;
            go_led  <= 1'b0;
            foul    <= 1'b0;
            done    <= 1'b0;
        end else begin
            pre_q <= ms_tick ? '0 : pre_q + 1'b1;
            case (state_q)
                IDLE: if (press_in) begin
                    state_q <= ARMED;
                    pre_q   <= '0;
                    wait_q  <= '0;
                    bcd_q   <= '0;
                end
                ARMED: if (press_in) begin
                    state_q <= FOUL;
                    pre_q   <= '0;
                    foul    <= 1'b1;
                end else if (ms_tick) begin
                    wait_q <= wait_q + 1'b1;
                    if (wait_q == WW'(WAIT_MS - 1)) begin
                        state_q <= GO;
                        pre_q   <= '0;
                        go_led  <= 1'b1;
                    end
                end
                GO: if (press_in) begin
                    state_q <= DONE;
                    pre_q   <= '0;
                    go_led  <= 1'b0;
                    done    <= 1'b1;
                end else if (ms_tick && !sat) begin
                    bcd_q <= bcd_d;
                end
                DONE: if (press_in) begin
                    state_q <= IDLE;
                    pre_q   <= '0;
                    done    <= 1'b0;
                end
                FOUL: if (press_in) begin
                    state_q <= IDLE;
                    pre_q   <= '0;
                    foul    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    pre_q   <= '0;
                    go_led  <= 1'b0;
                    foul    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end
endmodule
